dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
Sequences the MEM stage of the 5-stage MIPS pipeline against a variable-latency data memory with a req/ack handshake.
- Takes the registered MEM-stage fields from the execute-memory pipeline register: valid, load, store, address, store data.
- Drives the memory bus, stalls upstream pipeline registers until the access completes, and presents load data to writeback.
- Handles misaligned-address and timeout faults, and flushes that arrive during an outstanding access.

Parameters:
TIMEOUT, 16, maximum BUSY cycles without ack before the access is aborted with an error (must be >= 1).
ADDR_W, 32, data memory address width.
DATA_W, 32, data word width; access is word-only.

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
valid_i  input  1  MEM-stage instruction valid
is_load_i  input  1  MEM-stage instruction is a load (mem_to_reg)
is_store_i  input  1  MEM-stage instruction is a store (mem_wr)
addr_i  input  ADDR_W  ALU result used as byte address
wdata_i  input  DATA_W  store data
flush_i  input  1  hazard unit squashes the MEM-stage instruction
mem_req_o  output  1  bus request, held until ack
mem_we_o  output  1  bus write enable
mem_addr_o  output  ADDR_W  latched bus address
mem_wdata_o  output  DATA_W  latched bus write data
mem_ack_i  input  1  bus completion, one-cycle pulse
mem_rdata_i  input  DATA_W  bus read data, valid with ack
stall_o  output  1  freeze PC/IF/ID/EX/MEM pipeline registers
wb_clr_o  output  1  insert bubble into the MEM-WB register this cycle
rdata_o  output  DATA_W  load data to writeback
rdata_valid_o  output  1  rdata_o valid for the MEM-stage load this cycle
err_o  output  1  one-cycle fault pulse (misaligned or timeout)

Behaviour:
- States: IDLE, BUSY, DONE. Reset → IDLE.
- Reset values: all registered outputs are 0, and the timeout count is 0. While reset=1, stall_o=0 and wb_clr_o=0.
- access = valid_i & (is_load_i | is_store_i) & !flush_i. misaligned = addr_i[1:0] != 0.
- IDLE, access & !misaligned:
  - stall_o=1 combinationally.
  - Latch addr, wdata, we=is_store_i; clear the drop flag and count.
  - Go to BUSY.
- IDLE, access & misaligned:
  - No bus request; stall_o=0.
  - err_o=1 and wb_clr_o=1 for this cycle; stay in IDLE.
- IDLE, no access: stall_o=0. wb_clr_o=1 if valid_i & flush_i, else 0.
- BUSY:
  - mem_req_o=1, mem_we_o, mem_addr_o and mem_wdata_o are stable, stall_o=1.
  - On mem_ack_i: capture mem_rdata_i into rdata_o (loads only), go to DONE.
  - Without ack: count++. If count == TIMEOUT-1, set the timeout flag and go to DONE; mem_req_o drops on the next edge.
  - Ack and timeout in the same cycle: ack wins, no error.
- flush_i during BUSY:
  - Set the drop flag.
  - The bus transaction is never abandoned; wait for ack or timeout.
- DONE (exactly one cycle):
  - mem_req_o=0, stall_o=0, so the pipeline advances at the end of this cycle.
  - Load with no drop and no timeout: rdata_valid_o=1.
  - Drop or timeout: rdata_valid_o=0 and wb_clr_o=1.
  - Timeout: err_o=1.
  - Go to IDLE; the next instruction is evaluated there. The completed instruction never re-triggers.
- Minimum latency: detect cycle + 1 BUSY cycle + DONE = 3 cycles in MEM, of which 2 are stalled.
- mem_ack_i in IDLE or DONE: ignored, no state change.
- Reset mid-BUSY: mem_req_o=0 from the next cycle. The bus must tolerate an abandoned request.
- rdata_o holds its last value outside DONE. rdata_valid_o and err_o are single-cycle pulses.

Decomposition:
- Package mips_dmem_pkg holds:
  - state enum (IDLE/BUSY/DONE);
  - default TIMEOUT;
  - word-alignment mask constant;
  - error-cause codes, misaligned vs timeout, for future exception logic.
- Sub-module dmem_timeout_ctr:
  - inputs clr, en;
  - output expired, asserted when count == TIMEOUT-1 and en=1.

Test Plan:
1. Load at addr 0x100, ack 3 cycles after req with rdata 0xDEADBEEF → req high 3 cycles; stall high 4 cycles (detect + 3 BUSY); DONE: rdata_o=0xDEADBEEF, rdata_valid_o=1, err_o=0.
2. Store addr 0x204, wdata 0x12345678, ack in the first BUSY cycle → mem_we_o=1, addr and data stable while req is high; stall exactly 2 cycles; rdata_valid_o=0; a back-to-back store issues a new req 1 cycle after DONE.
3. Load at addr 0x102 → no mem_req_o; err_o=1 and wb_clr_o=1 for 1 cycle; stall_o=0.
4. Load, ack never returns, TIMEOUT=4 → req high 4 cycles; DONE: err_o=1, wb_clr_o=1, rdata_valid_o=0; an ack arriving later in IDLE is ignored.
5. Load, flush_i pulsed in the 2nd BUSY cycle, ack in the 3rd with rdata 0x55 → req held until ack; DONE: wb_clr_o=1, rdata_valid_o=0, err_o=0.
6. Reset asserted during BUSY → next cycle: mem_req_o=0, stall_o=0, state IDLE; a following aligned load completes normally.

Source files
------------

// File: rtl/mips_dmem_pkg.sv
// Shared types and constants for the MEM-stage data memory access controller.
package mips_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_TIMEOUT = 16;

  // Low address bits that must be zero for a word access.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Fault causes, kept for a future exception cause register.
  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2
  } err_cause_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data memory req/ack bus; the controller is the master, the memory the slave.
interface dmem_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/dmem_timeout_ctr.sv
// Counts BUSY cycles without ack; expired fires combinationally on the last allowed cycle.
module dmem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage sequencer for a variable-latency req/ack data memory: stalls the
// pipeline while an access is outstanding and reports misaligned/timeout faults.
module dmem_access_ctrl
  import mips_dmem_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              is_load_i,
  input  logic              is_store_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              flush_i,
  dmem_bus_if.master        bus,
  output logic              stall_o,
  output logic              wb_clr_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              err_o
);

  state_t state, state_nxt;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              drop_q;
  logic              tmo_q;

  logic access, misaligned, latch, ctr_clr, ctr_en, expired;

  assign access     = valid_i && (is_load_i || is_store_i) && !flush_i;
  assign misaligned = |(addr_i[1:0] & ALIGN_MASK);

  dmem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    stall_o       = 1'b0;
    wb_clr_o      = 1'b0;
    err_o         = 1'b0;
    rdata_valid_o = 1'b0;
    latch         = 1'b0;
    ctr_clr       = 1'b0;
    ctr_en        = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            err_o    = 1'b1;
            wb_clr_o = 1'b1;
          end else begin
            stall_o   = 1'b1;
            latch     = 1'b1;
            ctr_clr   = 1'b1;
            state_nxt = BUSY;
          end
        end else begin
          wb_clr_o = valid_i && flush_i;
        end
      end
      BUSY: begin
        stall_o = 1'b1;
        if (bus.mem_ack_i) begin
          state_nxt = DONE;
        end else begin
          ctr_en = 1'b1;
          if (expired) state_nxt = DONE;
        end
      end
      DONE: begin
        // Pipeline advances at the end of this cycle; a dropped or timed-out
        // instruction leaves as a bubble.
        rdata_valid_o = !we_q && !drop_q && !tmo_q;
        wb_clr_o      = drop_q || tmo_q;
        err_o         = tmo_q;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      stall_o       = 1'b0;
      wb_clr_o      = 1'b0;
      err_o         = 1'b0;
      rdata_valid_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      drop_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (latch) begin
        we_q    <= is_store_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        drop_q  <= 1'b0;
        tmo_q   <= 1'b0;
      end
      if (state == BUSY) begin
        // The bus transaction always runs to ack or timeout, even when squashed.
        if (flush_i) drop_q <= 1'b1;
        if (bus.mem_ack_i && !we_q) rdata_q <= bus.mem_rdata_i;
        if (!bus.mem_ack_i && expired) tmo_q <= 1'b1;
      end
    end
  end

  assign bus.mem_req_o   = (state == BUSY);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign rdata_o         = rdata_q;

endmodule
